// File: rtl/alarm_timer.sv
// alarm_timer: countdown timer with four programmable intervals for the car-alarm FSM.
//
// Parameters : CLK_HZ clock cycles per one-second tick; T_*_DEFAULT reset values of
//              intervals 00 (arm), 01 (driver), 10 (passenger), 11 (alarm-on).
// Ports      : clk, reset_n (async, active low)
//              start_timer/interval        - load selected interval and (re)start
//              reprogram/time_parameter_selector/time_value - write an interval register
//              expired       - level, set at end of countdown until next start/reset
//              running       - countdown in progress
//              seconds_left  - remaining seconds (for the hex display)
//              one_hz_enable - one-cycle pulse per second tick while counting
// Build      : define ALARM_TIMER_ZERO_GUARD_EN to store 0-second intervals as 1.
module alarm_timer #(
    parameter int CLK_HZ              = 27000000,
    parameter int T_ARM_DEFAULT       = 6,
    parameter int T_DRIVER_DEFAULT    = 8,
    parameter int T_PASSENGER_DEFAULT = 15,
    parameter int T_ALARM_DEFAULT     = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_parameter_selector,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       running,
    output logic [3:0] seconds_left,
    output logic       one_hz_enable
);
    localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_HZ - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    regs_q [4];
    logic [3:0]    regs_d [4];
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    secs_q, secs_d;
    logic          expired_q, expired_d;
    logic          zero_pend_q, zero_pend_d;
    logic          tick_q, tick_d;
    logic [3:0]    wr_value, load_value;
    logic          tick;

    function automatic logic [3:0] guard(input logic [3:0] v);
`ifdef ALARM_TIMER_ZERO_GUARD_EN
        return (v == 4'd0) ? 4'd1 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        wr_value    = guard(time_value);
        // write-through: a same-edge write to the started interval is loaded directly
        load_value  = (reprogram && time_parameter_selector == interval) ? wr_value : regs_q[interval];
        tick        = (state_q == COUNT) && (div_q == DIV_MAX);
        regs_d      = regs_q;
        state_d     = state_q;
        div_d       = div_q;
        secs_d      = secs_q;
        // a zero-length load expires one edge after its start
        expired_d   = expired_q | zero_pend_q;
        zero_pend_d = 1'b0;
        tick_d      = tick && !start_timer;
        if (reprogram)
            regs_d[time_parameter_selector] = wr_value;
        if (start_timer) begin
            secs_d      = load_value;
            div_d       = '0;
            expired_d   = 1'b0;
            zero_pend_d = (load_value == 4'd0);
            state_d     = (load_value != 4'd0) ? COUNT : IDLE;
        end else if (state_q == COUNT) begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                secs_d = secs_q - 4'd1;
                if (secs_q == 4'd1) begin
                    state_d   = IDLE;
                    expired_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            regs_q[0]   <= guard(4'(T_ARM_DEFAULT));
            regs_q[1]   <= guard(4'(T_DRIVER_DEFAULT));
            regs_q[2]   <= guard(4'(T_PASSENGER_DEFAULT));
            regs_q[3]   <= guard(4'(T_ALARM_DEFAULT));
            div_q       <= '0;
            secs_q      <= 4'd0;
            expired_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            div_q       <= div_d;
            secs_q      <= secs_d;
            expired_q   <= expired_d;
            zero_pend_q <= zero_pend_d;
            tick_q      <= tick_d;
        end
    end

    assign expired       = expired_q;
    assign running       = (state_q == COUNT);
    assign seconds_left  = secs_q;
    assign one_hz_enable = tick_q;
endmodule

// File: tb/tb_alarm_timer.sv
// tb_alarm_timer: directed self-checking bench for alarm_timer with CLK_HZ=4.
module tb_alarm_timer;
    localparam int HZ = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_timer = 1'b0;
    logic [1:0] interval = 2'd0;
    logic       reprogram = 1'b0;
    logic [1:0] time_parameter_selector = 2'd0;
    logic [3:0] time_value = 4'd0;
    logic       expired, running, one_hz_enable;
    logic [3:0] seconds_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st;
        logic [1:0] iv;
        logic       rp;
        logic [1:0] sel;
        logic [3:0] val;
        logic [3:0] e_secs;
        logic       e_run;
        logic       e_exp;
    } vec_t;

    vec_t vt [9];

    alarm_timer #(.CLK_HZ(HZ)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start_timer             (start_timer),
        .interval                (interval),
        .reprogram               (reprogram),
        .time_parameter_selector (time_parameter_selector),
        .time_value              (time_value),
        .expired                 (expired),
        .running                 (running),
        .seconds_left            (seconds_left),
        .one_hz_enable           (one_hz_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [1:0] iv, input logic rp,
                         input logic [1:0] sel, input logic [3:0] val);
        start_timer = st;
        interval = iv;
        reprogram = rp;
        time_parameter_selector = sel;
        time_value = val;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic start(input logic [1:0] iv);
        drive(1'b1, iv, 1'b0, 2'd0, 4'd0);
        step();
        idle_in();
    endtask

    // steps until expired is seen or the limit runs out; pulses counts one_hz
    // samples strictly before the expiry sample
    task automatic run_to_expiry(input int limit, output int edges, output int pulses);
        edges = 0;
        pulses = 0;
        while (edges < limit && !expired) begin
            step();
            edges++;
            if (one_hz_enable && !expired) pulses++;
        end
    endtask

    initial begin
        int edges, pulses, highs;
        vt[0] = '{1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 4'd6,  1'b1, 1'b0};
        vt[1] = '{1'b1, 2'd1, 1'b0, 2'd0, 4'd0, 4'd8,  1'b1, 1'b0};
        vt[2] = '{1'b1, 2'd2, 1'b0, 2'd0, 4'd0, 4'd15, 1'b1, 1'b0};
        vt[3] = '{1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 4'd10, 1'b1, 1'b0};
        vt[4] = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd5, 4'd10, 1'b1, 1'b0};
        vt[5] = '{1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 4'd5,  1'b1, 1'b0};
        vt[6] = '{1'b1, 2'd0, 1'b1, 2'd0, 4'd9, 4'd9,  1'b1, 1'b0};
        vt[7] = '{1'b1, 2'd2, 1'b1, 2'd1, 4'd7, 4'd15, 1'b1, 1'b0};
        vt[8] = '{1'b1, 2'd1, 1'b0, 2'd0, 4'd0, 4'd7,  1'b1, 1'b0};

        #1;
        chk("reset secs", seconds_left, 0);
        chk("reset running", running, 0);
        chk("reset expired", expired, 0);
        chk("reset one_hz", one_hz_enable, 0);
        do_reset();
        chk("post-reset running", running, 0);
        chk("post-reset expired", expired, 0);

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].st, vt[i].iv, vt[i].rp, vt[i].sel, vt[i].val);
            step();
            idle_in();
            chk($sformatf("vec%0d secs", i), seconds_left, vt[i].e_secs);
            chk($sformatf("vec%0d running", i), running, vt[i].e_run);
            chk($sformatf("vec%0d expired", i), expired, vt[i].e_exp);
        end

        // driver interval: 8 s, 32 edges, 7 pulses before the final tick
        do_reset();
        start(2'd1);
        chk("A secs", seconds_left, 8);
        chk("A running", running, 1);
        chk("A expired", expired, 0);
        run_to_expiry(40, edges, pulses);
        chk("A expiry edges", edges, 32);
        chk("A pulses before final", pulses, 7);
        chk("A final pulse", one_hz_enable, 1);
        chk("A running at expiry", running, 0);
        chk("A secs at expiry", seconds_left, 0);
        step();
        step();
        chk("A pulse single cycle", one_hz_enable, 0);
        chk("A expired held", expired, 1);

        // reprogram passenger to 3 s; start clears stale expiry
        drive(1'b0, 2'd0, 1'b1, 2'd2, 4'd3);
        step();
        idle_in();
        chk("B expired before start", expired, 1);
        start(2'd2);
        chk("B secs", seconds_left, 3);
        chk("B expired cleared", expired, 0);
        run_to_expiry(20, edges, pulses);
        chk("B expiry edges", edges, 12);
        do_reset();
        start(2'd2);
        chk("B default restored", seconds_left, 15);

        // restart mid-countdown at edge 9
        start(2'd3);
        chk("C secs", seconds_left, 10);
        repeat (8) step();
        chk("C secs at edge 8", seconds_left, 8);
        chk("C running at edge 8", running, 1);
        start(2'd0);
        chk("C restart secs", seconds_left, 6);
        chk("C restart running", running, 1);
        chk("C restart expired", expired, 0);
        run_to_expiry(40, edges, pulses);
        chk("C expiry edges", edges, 24);

        // same-edge write and start
        drive(1'b1, 2'd1, 1'b1, 2'd1, 4'd2);
        step();
        idle_in();
        chk("D secs", seconds_left, 2);
        chk("D expired cleared", expired, 0);
        run_to_expiry(20, edges, pulses);
        chk("D expiry edges", edges, 8);

        // zero-valued interval
        drive(1'b0, 2'd0, 1'b1, 2'd0, 4'd0);
        step();
        idle_in();
        start(2'd0);
`ifdef ALARM_TIMER_ZERO_GUARD_EN
        chk("E secs", seconds_left, 1);
        chk("E running", running, 1);
        chk("E expired", expired, 0);
        run_to_expiry(20, edges, pulses);
        chk("E expiry edges", edges, 4);
`else
        chk("E secs", seconds_left, 0);
        chk("E running", running, 0);
        chk("E expired after start", expired, 0);
        step();
        chk("E expired next edge", expired, 1);
        chk("E running next edge", running, 0);
        step();
        chk("E expired held", expired, 1);
        chk("E running held", running, 0);
`endif

        // asynchronous reset mid-countdown
        start(2'd2);
        chk("F secs", seconds_left, 15);
        repeat (10) step();
        chk("F secs at edge 10", seconds_left, 13);
        #2;
        reset_n = 1'b0;
        #1;
        chk("F async running", running, 0);
        chk("F async expired", expired, 0);
        chk("F async secs", seconds_left, 0);
        step();
        step();
        reset_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (expired || running) highs++;
        end
        chk("F no expiry after reset", highs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alarm_timer.md
Name: alarm_timer

Overview:
- Countdown timer that serves the car-alarm FSM.
- The FSM selects an interval and pulses start_timer. This block counts down the programmed number of seconds and raises expired.
- Holds four user-programmable delay registers, written through the reprogram interface.
- Sits between the alarm FSM and the labkit switch/button inputs. seconds_left is also exported for the hex display.

Parameters:
CLK_HZ, 27000000, system clock cycles per one-second tick (benches use a small value, e.g. 4)
T_ARM_DEFAULT, 6, reset value of interval 00 (arming delay)
T_DRIVER_DEFAULT, 8, reset value of interval 01 (driver-door delay)
T_PASSENGER_DEFAULT, 15, reset value of interval 10 (passenger-door delay)
T_ALARM_DEFAULT, 10, reset value of interval 11 (alarm-on time)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start_timer  input  1  sampled each edge; high = load selected interval and (re)start
interval  input  2  interval select, sampled with start_timer
reprogram  input  1  sampled each edge; high = write time_value into selected register
time_parameter_selector  input  2  register to write
time_value  input  4  seconds value to write (0-15)
expired  output  1  level; high once countdown completes, held until next start or reset
running  output  1  high while a countdown is in progress
seconds_left  output  4  current remaining seconds
one_hz_enable  output  1  single-cycle pulse on each one-second tick while running

Behaviour:
- Reset (reset_n low, asynchronous): interval registers take the *_DEFAULT values. Counter = 0, divider = 0, running = 0, expired = 0, one_hz_enable = 0. A reset mid-countdown aborts it with no expired.
- Interval registers: four 4-bit registers indexed 00..11.
  - An edge with reprogram=1 writes time_value to register[time_parameter_selector].
  - A write during a countdown does not affect the running count.
- Start: an edge with start_timer=1 sets seconds_left <= value(interval), divider <= 0 and expired <= 0.
  - running <= 1 if value is non-zero.
  - expired is therefore low in the cycle after start, so the FSM never sees a stale expiry.
- Simultaneous reprogram and start to the same index: the start loads the new time_value (write-through).
- Start while running: restarts from the new value; the old countdown is discarded.
- Counting: while running, divider increments each cycle. At divider == CLK_HZ-1:
  - divider wraps to 0 and one_hz_enable pulses high for one cycle;
  - seconds_left decrements.
  - Divider width is clog2(CLK_HZ).
- Completion: on the tick where seconds_left goes 1 -> 0, running <= 0 and expired <= 1 on the same edge. For load value N >= 1, expired rises exactly N*CLK_HZ edges after the start edge.
- Zero load (N=0): running stays 0; expired <= 1 on the edge after the start edge (one cycle later).
- Idle: divider held at 0, one_hz_enable = 0, seconds_left held. expired stays at its last value until the next start or reset.
- States: IDLE (running=0) and COUNT (running=1). IDLE->COUNT on start with N>0. COUNT->IDLE on final tick. IDLE->IDLE with expired set on start with N=0.

Optional Feature:
- Macro ALARM_TIMER_ZERO_GUARD_EN.
- Defined: any write of time_value=0 stores 1, and *_DEFAULT values of 0 are also forced to 1. Every countdown then lasts at least one second, and the zero-load path is unreachable.
- Undefined: 0 is stored as written and the zero-load behaviour above applies.

Test Plan:
- CLK_HZ=4, reset release, start_timer=1 interval=01 -> seconds_left=8, running=1, expired=0; expired rises exactly 32 edges after start; seven one_hz_enable pulses before the final tick, eight in total.
- reprogram sel=10 value=3, then start interval=10 -> expired exactly 12 edges after start; reset again -> register reads back 15 (start shows seconds_left=15).
- Start interval=11 (10 s), restart at edge 9 with interval=00 -> expired clears, seconds_left=6, expired 24 edges after the restart edge.
- Same-edge reprogram sel=01 value=2 and start interval=01 -> seconds_left=2, expired 8 edges later.
- Write value 0 to sel=00, start interval=00 -> macro undefined: expired high on next edge, running never high; macro defined: seconds_left=1, expired after 4 edges.
- reset_n pulled low at edge 10 of a countdown -> running=0, expired=0, seconds_left=0 immediately (asynchronously), no expiry afterwards.
